// File: rtl/mem_burst_seq.sv
// mem_burst_seq: multi-word load/store sequencer for the single-port data memory.
// Issues one word per cycle, gathers read words RD_LAT cycles later, and stalls the PC until done.
module mem_burst_seq #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 2,
    parameter int RD_LAT    = 0,
    parameter int LEN_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [LEN_W-1:0]            req_len_m1,
    input  logic [MAX_WORDS*DATA_W-1:0] req_wdata,
    output logic                        rsp_valid,
    output logic [MAX_WORDS*DATA_W-1:0] rsp_rdata,
    output logic                        stall,
    output logic                        CEN,
    output logic                        WEN,
    output logic                        OEN,
    output logic [ADDR_W-1:0]           A,
    output logic [DATA_W-1:0]           Data2Mem,
    input  logic [DATA_W-1:0]           ReadDataMem
);
    localparam int BUS_W = MAX_WORDS * DATA_W;
    localparam logic [LEN_W-1:0] LAST_MAX = LEN_W'(MAX_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state, state_d;
    logic [LEN_W-1:0]   k, k_d, last_q, last_d;
    logic [1:0]         drain_cnt, drain_d;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BUS_W-1:0]   wdata_q;
    logic               accept, issue, iss_load;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BUS_W-1:0]   sel_wdata;
    logic               cen_d, wen_d, oen_d;
    logic [ADDR_W-1:0]  a_d;
    logic [DATA_W-1:0]  d2m_d;
    logic               cap_v;
    logic [LEN_W-1:0]   cap_idx;

    function automatic logic [DATA_W-1:0] word_at(input logic [BUS_W-1:0] v,
                                                  input logic [LEN_W-1:0] idx);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned w = 0; w < MAX_WORDS; w++)
            if (idx == LEN_W'(w)) r = v[(MAX_WORDS-w)*DATA_W-1 -: DATA_W];
        return r;
    endfunction

    assign accept    = (state == IDLE) && req_valid;
    assign req_ready = (state == IDLE);
    assign stall     = accept || (state == ISSUE) || (state == DRAIN);
    assign last_d    = (req_len_m1 > LAST_MAX) ? LAST_MAX : req_len_m1;
    assign iss_load  = (state == ISSUE) && !wr_q;

    // Word 0 goes out the cycle right after acceptance, so it is taken straight from the request.
    assign sel_write = (state == IDLE) ? req_write : wr_q;
    assign sel_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign sel_wdata = (state == IDLE) ? req_wdata : wdata_q;

    always_comb begin
        state_d = state;
        k_d     = k;
        drain_d = drain_cnt;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_d = ISSUE;
                    k_d     = '0;
                    issue   = 1'b1;
                end
            end
            ISSUE: begin
                if (k == last_q) begin
                    if (wr_q || RD_LAT == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end else begin
                    k_d   = k + 1'b1;
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'(RD_LAT - 1)) state_d = DONE;
                else                             drain_d = drain_cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        cen_d = !issue;
        wen_d = !(issue && sel_write);
        oen_d = !(issue && !sel_write);
        a_d   = issue ? ADDR_W'(sel_addr + ADDR_W'(k_d)) : '0;
        d2m_d = (issue && sel_write) ? word_at(sel_wdata, k_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            drain_cnt <= '0;
            CEN       <= 1'b1;
            WEN       <= 1'b1;
            OEN       <= 1'b1;
            A         <= '0;
            Data2Mem  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_d;
            k         <= k_d;
            drain_cnt <= drain_d;
            CEN       <= cen_d;
            WEN       <= wen_d;
            OEN       <= oen_d;
            A         <= a_d;
            Data2Mem  <= d2m_d;
            rsp_valid <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            last_q  <= last_d;
            wdata_q <= req_wdata;
        end
    end

    // Read capture follows the issue slots through its own pipeline, independent of DRAIN.
    if (RD_LAT == 0) begin : g_nolat
        assign cap_v   = iss_load;
        assign cap_idx = k;
    end else begin : g_lat
        logic [RD_LAT-1:0] pv;
        logic [LEN_W-1:0]  pidx [RD_LAT];
        always_ff @(posedge clk) begin
            if (rst) begin
                pv <= '0;
            end else begin
                pv[0] <= iss_load;
                for (int unsigned i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
            end
            pidx[0] <= k;
            for (int unsigned i = 1; i < RD_LAT; i++) pidx[i] <= pidx[i-1];
        end
        assign cap_v   = pv[RD_LAT-1];
        assign cap_idx = pidx[RD_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            rsp_rdata <= '0;
        end else if (cap_v) begin
            for (int unsigned w = 0; w < MAX_WORDS; w++)
                if (cap_idx == LEN_W'(w))
                    rsp_rdata[(MAX_WORDS-w)*DATA_W-1 -: DATA_W] <= ReadDataMem;
        end
    end
endmodule

// File: tb/tb_mem_burst_seq.sv
// Bench for mem_burst_seq: four parameterisations checked cycle by cycle against a transfer-level model.
module tb_mem_burst_seq;
    localparam int NI = 4;

    function automatic int mw_of(input int g);
        return (g == 0) ? 2 : (g == 3) ? 3 : 4;
    endfunction
    function automatic int lat_of(input int g);
        return (g == 1) ? 2 : (g == 3) ? 1 : 0;
    endfunction

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NI-1:0]         req_valid, req_write, req_ready, rsp_valid, stall, cen, wen, oen;
    logic [NI-1:0][6:0]    req_addr, a;
    logic [NI-1:0][2:0]    req_len_m1;
    logic [NI-1:0][127:0]  req_wdata, rsp_rdata;
    logic [NI-1:0][31:0]   d2m, rdm;
    logic [31:0]           salt;
    logic [31:0]           wd [4];
    int                    n_cmp = 0;
    int                    n_bad = 0;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int MW = mw_of(g);
        localparam int LT = lat_of(g);
        localparam int LW = (MW > 1) ? $clog2(MW) : 1;
        logic [MW*32-1:0] rdata_n;
        logic             rd_now;
        logic [31:0]      p1, p2;

        mem_burst_seq #(.DATA_W(32), .ADDR_W(7), .MAX_WORDS(MW), .RD_LAT(LT)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
            .req_addr(req_addr[g]), .req_len_m1(req_len_m1[g][LW-1:0]),
            .req_wdata(req_wdata[g][MW*32-1:0]),
            .rsp_valid(rsp_valid[g]), .rsp_rdata(rdata_n), .stall(stall[g]),
            .CEN(cen[g]), .WEN(wen[g]), .OEN(oen[g]), .A(a[g]),
            .Data2Mem(d2m[g]), .ReadDataMem(rdm[g])
        );

        assign rsp_rdata[g] = 128'(rdata_n);
        assign rd_now = !cen[g] && !oen[g];
        // Memory model: word at address x reads as (0x100 + x) ^ salt, delivered LT cycles after issue.
        always_ff @(posedge clk) begin
            p1 <= rd_now ? ((32'h100 + {25'b0, a[g]}) ^ salt) : JUNK;
            p2 <= p1;
        end
        assign rdm[g] = (LT == 0) ? (rd_now ? ((32'h100 + {25'b0, a[g]}) ^ salt) : JUNK)
                                  : (LT == 1) ? p1 : p2;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one transfer from the current (post-negedge) point of an idle instance and checks every cycle.
    task automatic run_xfer(input int g, input bit wr, input logic [6:0] addr, input int len_m1,
                            input bit keep);
        int           mw, lat, len, done_c;
        logic [127:0] vec, exp_rd;
        logic [6:0]   ea;
        mw  = mw_of(g);
        lat = wr ? 0 : lat_of(g);
        len = (len_m1 + 1 > mw) ? mw : len_m1 + 1;
        vec = '0;
        exp_rd = '0;
        for (int k = 0; k < mw; k++) vec[(mw-k)*32-1 -: 32] = wd[k];
        if (!wr)
            for (int k = 0; k < len; k++) begin
                ea = addr + 7'(k);
                exp_rd[(mw-k)*32-1 -: 32] = (32'h100 + {25'b0, ea}) ^ salt;
            end
        req_write[g]  = wr;
        req_addr[g]   = addr;
        req_len_m1[g] = 3'(len_m1);
        req_wdata[g]  = vec;
        req_valid[g]  = 1'b1;
        #1;
        chk("ready_stall_idle", 128'({req_ready[g], stall[g]}), 128'(2'b11));
        done_c = len + lat + 1;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            if (c == 1 && !keep) req_valid[g] = 1'b0;
            #1;
            if (c <= len) begin
                ea = addr + 7'(c - 1);
                chk("issue_strobes", 128'({cen[g], wen[g], oen[g]}), 128'({1'b0, !wr, wr}));
                chk("issue_addr", 128'(a[g]), 128'(ea));
                chk("issue_data", 128'(d2m[g]), 128'(wr ? wd[c-1] : 32'h0));
                chk("issue_ctl", 128'({req_ready[g], stall[g], rsp_valid[g]}), 128'(3'b010));
            end else if (c < done_c) begin
                chk("drain_strobes", 128'({cen[g], wen[g], oen[g]}), 128'(3'b111));
                chk("drain_ctl", 128'({req_ready[g], stall[g], rsp_valid[g]}), 128'(3'b010));
            end else if (c == done_c) begin
                chk("done_strobes", 128'({cen[g], wen[g], oen[g]}), 128'(3'b111));
                chk("done_ctl", 128'({req_ready[g], stall[g], rsp_valid[g]}), 128'(3'b001));
                chk("done_rdata", rsp_rdata[g], exp_rd);
            end else begin
                chk("idle_ctl", 128'({req_ready[g], stall[g], rsp_valid[g]}), 128'({2'b10 | {1'b0, keep}, 1'b0}));
                chk("idle_rdata", rsp_rdata[g], exp_rd);
            end
        end
    endtask

    task automatic chk_reset_state(input int g, input bit vld);
        chk("rst_strobes", 128'({cen[g], wen[g], oen[g]}), 128'(3'b111));
        chk("rst_addr_data", 128'({a[g], d2m[g]}), 128'd0);
        chk("rst_ctl", 128'({req_ready[g], stall[g], rsp_valid[g]}), 128'({1'b1, vld, 1'b0}));
        chk("rst_rdata", rsp_rdata[g], 128'd0);
    endtask

    initial begin
        int g, lw, gap;
        logic [6:0] ad;
        rst = 1'b1;
        req_valid = '1; req_write = '0; req_addr = '0; req_len_m1 = '0; req_wdata = '0;
        salt = 32'h0;
        for (int k = 0; k < 4; k++) wd[k] = 32'h0;

        // Reset held three cycles with requests pending: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            for (int j = 0; j < NI; j++) chk_reset_state(j, 1'b1);
        end
        rst = 1'b0;
        req_valid[3:1] = '0;

        // Double store on default parameters, accepted on the first edge after reset release.
        wd[0] = 32'hAAAA_0001; wd[1] = 32'h5555_0002;
        run_xfer(0, 1'b1, 7'h10, 1, 1'b0);

        // 4-word load with latency 2 wrapping the address space.
        run_xfer(1, 1'b0, 7'h7E, 3, 1'b0);

        // Single-word load into a 4-word result buffer.
        salt = $urandom;
        run_xfer(2, 1'b0, 7'($urandom), 0, 1'b0);

        // Length clamped to MAX_WORDS=3 for a 4-word request, load and store.
        run_xfer(3, 1'b0, 7'h7F, 3, 1'b0);
        for (int k = 0; k < 4; k++) wd[k] = $urandom;
        run_xfer(3, 1'b1, 7'h05, 3, 1'b0);

        // Reset during the second issue cycle of a 4-word load.
        req_write[1] = 1'b0; req_addr[1] = 7'h20; req_len_m1[1] = 3'd3; req_valid[1] = 1'b1;
        @(negedge clk); req_valid[1] = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        chk_reset_state(1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("post_rst_no_rsp", 128'({rsp_valid[1], cen[1]}), 128'(2'b01));
        end
        salt = $urandom;
        run_xfer(1, 1'b0, 7'h33, 0, 1'b0);

        // Back-to-back stores with req_valid held across the first DONE.
        for (int k = 0; k < 4; k++) wd[k] = $urandom;
        run_xfer(0, 1'b1, 7'h40, 1, 1'b1);
        for (int k = 0; k < 4; k++) wd[k] = $urandom;
        run_xfer(0, 1'b1, 7'h7F, 1, 1'b0);

        // Randomised transfers across all instances.
        for (int it = 0; it < 40; it++) begin
            g  = $urandom_range(0, NI - 1);
            lw = (g == 0) ? 1 : 2;
            ad = 7'($urandom);
            salt = $urandom;
            for (int k = 0; k < 4; k++) wd[k] = $urandom;
            run_xfer(g, 1'($urandom_range(0, 1)), ad, $urandom_range(0, (1 << lw) - 1), 1'b0);
            gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) begin
                @(negedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
